// File: rtl/alu_mdu_exec_if.sv
// rtl/alu_mdu_exec_if.sv - operation/result bus for the alu_mdu_exec execute unit
//
// master: drives in_valid, op, a, b, shamt; observes every result/status signal.
// slave : the execute unit; accepts the operation and returns result/status.
// Signals:
//   in_valid / in_ready    operation handshake (accept when both high)
//   op, a, b, shamt        operation code, operands, shift amount
//   out_valid              one-cycle result pulse
//   result, zero           registered result and (result == 0)
//   hi, lo                 architectural HI/LO registers
//   busy                   multi-cycle MDU iteration in progress
//   div_by_zero            qualifies out_valid of a DIV/DIVU with b == 0

interface alu_mdu_exec_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             div_by_zero;

    modport master (
        output in_valid, op, a, b, shamt,
        input  in_ready, out_valid, result, zero, hi, lo, busy, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b, shamt,
        output in_ready, out_valid, result, zero, hi, lo, busy, div_by_zero
    );
endinterface

// File: rtl/alu_mdu_exec.sv
// rtl/alu_mdu_exec.sv - execute stage: single-cycle ALU plus iterative multiply/divide unit
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   alu_mdu_exec_if.slave (operation handshake, registered result, hi/lo, status)
// Configuration macro: ALU_MDU_EN
//   defined   : shift-add multiplier, restoring divider, HI/LO, ops 10-15 implemented
//   undefined : ops 10-15 complete in one cycle with result 0; busy/hi/lo/div_by_zero
//               tied to 0, in_ready tied to 1, no multi-cycle state

module alu_mdu_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    alu_mdu_exec_if.slave bus
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    logic                 accept;
    logic                 alu_accept;
    logic [WIDTH-1:0]     alu_res;
    logic [SHW-1:0]       shamt_w;

    logic                 out_valid_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;

    assign shamt_w = bus.shamt;
    assign accept  = bus.in_valid && bus.in_ready;

`ifdef ALU_MDU_EN
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;
    localparam logic [SHW:0] LAST_ITER = (SHW+1)'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t               state_q, state_d;
    logic [SHW:0]         cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_nx;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     a_q;
    logic                 neg_q;
    logic                 rem_neg_q;
    logic                 dz_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 dbz_q;

    logic                 op_is_mul, op_is_div, mdu_op, mdu_signed;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 last;
    logic                 finish;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [WIDTH-1:0]     quo_raw, rem_raw;
    logic [WIDTH-1:0]     fin_hi, fin_lo;

    assign op_is_mul  = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign op_is_div  = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign mdu_op     = op_is_mul || op_is_div;
    assign mdu_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign alu_accept = accept && !mdu_op;

    // Signed ops iterate on magnitudes; the sign is restored on completion.
    assign mag_a = (mdu_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b = (mdu_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.in_ready = (state_q == S_IDLE);
    assign last         = (cnt_q == LAST_ITER);
    assign finish       = (state_q != S_IDLE) && last;

    // One iteration step. MUL: acc = {partial product, remaining multiplier bits},
    // add the multiplicand into the top half when the low bit is set, shift right.
    // DIV: acc = {remainder, dividend bits still to shift in}, restoring step.
    always_comb begin
        mul_sum   = '0;
        div_shift = '0;
        div_trial = '0;
        acc_nx    = acc_q;
        if (state_q == S_MUL) begin
            mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
            acc_nx  = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (state_q == S_DIV) begin
            div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
            div_trial = div_shift - {1'b0, opnd_q};
            // A non-restored remainder is always below the divisor, so the
            // dropped top bit of div_shift is zero in the else branch.
            if (div_shift >= {1'b0, opnd_q})
                acc_nx = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_nx = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero override applied to the final step.
    always_comb begin
        prod_signed = neg_q ? -acc_nx : acc_nx;
        quo_raw     = acc_nx[WIDTH-1:0];
        rem_raw     = acc_nx[2*WIDTH-1:WIDTH];
        fin_hi      = prod_signed[2*WIDTH-1:WIDTH];
        fin_lo      = prod_signed[WIDTH-1:0];
        if (state_q == S_DIV) begin
            if (dz_q) begin
                fin_lo = '1;
                fin_hi = a_q;
            end else begin
                fin_lo = neg_q     ? -quo_raw : quo_raw;
                fin_hi = rem_neg_q ? -rem_raw : rem_raw;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && op_is_mul)
                    state_d = S_MUL;
                else if (accept && op_is_div)
                    state_d = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (last)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_q       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (accept && mdu_op) begin
            cnt_q     <= '0;
            a_q       <= bus.a;
            neg_q     <= mdu_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rem_neg_q <= mdu_signed && bus.a[WIDTH-1];
            dz_q      <= (bus.b == '0);
            if (op_is_mul) begin
                acc_q  <= {{WIDTH{1'b0}}, mag_b};
                opnd_q <= mag_a;
            end else begin
                acc_q  <= {{WIDTH{1'b0}}, mag_a};
                opnd_q <= mag_b;
            end
        end else if (state_q != S_IDLE) begin
            acc_q <= acc_nx;
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign alu_accept      = accept;
    assign bus.busy        = 1'b0;
    assign bus.in_ready    = 1'b1;
    assign bus.hi          = '0;
    assign bus.lo          = '0;
    assign bus.div_by_zero = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_ADD: alu_res = bus.a + bus.b;
            OP_SUB: alu_res = bus.a - bus.b;
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_NOR: alu_res = ~(bus.a | bus.b);
            OP_SLT: alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_SLL: alu_res = bus.b << shamt_w;
            OP_SRL: alu_res = bus.b >> shamt_w;
            OP_SRA: alu_res = $unsigned($signed(bus.b) >>> shamt_w);
`ifdef ALU_MDU_EN
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
`endif
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
`ifdef ALU_MDU_EN
            hi_q        <= '0;
            lo_q        <= '0;
            dbz_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
`ifdef ALU_MDU_EN
            dbz_q       <= 1'b0;
`endif
            if (alu_accept) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
                zero_q      <= (alu_res == '0);
            end
`ifdef ALU_MDU_EN
            else if (finish) begin
                out_valid_q <= 1'b1;
                result_q    <= fin_lo;
                zero_q      <= (fin_lo == '0);
                hi_q        <= fin_hi;
                lo_q        <= fin_lo;
                dbz_q       <= (state_q == S_DIV) && dz_q;
            end
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
`ifdef ALU_MDU_EN
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
`endif

endmodule
